cache_mem_arbiter: RTL and testbench

Arbitrates the single shared main memory between the instruction cache and the data cache, and sequences the multi-word block fills they need on a miss. Sits inside the cache controller, between the two cache tag/data arrays and the pipelined main-memory instance. Issues one word request per cycle, steers returning words into the requesting cache's data array, writes the tag on the last word, and performs single-word write-through stores for the D-cache.

---
 rtl/cache_mem_arbiter_if.sv | 42 ++++
 rtl/cache_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the cache-side arbiter and the two caches plus the pipelined main memory.
// Requests are levels held by the requester until its done pulse; the arbiter samples them only while idle.
interface cache_mem_arbiter_if #(parameter int ADDR_W = 16);
    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;
    logic              dcache_wr;
    logic [ADDR_W-1:0] dcache_wr_addr;
    logic [15:0]       dcache_wr_data;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data_in;
    logic [15:0]       mem_data_out;
    logic              mem_data_valid;
    logic              fill_we;
    logic              fill_target;
    logic [2:0]        fill_word;
    logic [15:0]       fill_data;
    logic              tag_we;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_done;
    logic              busy;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  dcache_wr, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_in,
        output fill_we, fill_target, fill_word, fill_data, tag_we,
        output i_fill_done, d_fill_done, d_wr_done, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output dcache_wr, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_in,
        input  fill_we, fill_target, fill_word, fill_data, tag_we,
        input  i_fill_done, d_fill_done, d_wr_done, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined main memory between I- and D-cache: block fills with one issue per cycle,
// word-by-word steering into the target array, tag write on the last word, and D-cache store write-through.
module cache_mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_mem_arbiter_if.master   bus,
    output logic [1:0]            o_dbg_state
);
    localparam logic [3:0] NWORDS    = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

    // The word counters and the 3-bit fill_word port assume an 8-word block.
    if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1 || ADDR_W < 5) begin : g_bad_cfg
        $error("cache_mem_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_target, w_target_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [15:0]       r_wr_data, w_wr_data_nxt;
    logic [3:0]        r_issue_cnt, w_issue_nxt;
    logic [3:0]        r_recv_cnt, w_recv_nxt;

    logic              w_mem_enable, w_mem_wr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [15:0]       w_mem_data_in;
    logic              w_fill_we, w_tag_we;
    logic [2:0]        w_fill_word;
    logic [15:0]       w_fill_data;
    logic              w_i_done, w_d_done, w_wr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_target    <= 1'b0;
            r_base      <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_base      <= w_base_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_recv_cnt  <= w_recv_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_base_nxt    = r_base;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_issue_nxt   = r_issue_cnt;
        w_recv_nxt    = r_recv_cnt;
        w_mem_enable  = 1'b0;
        w_mem_wr      = 1'b0;
        w_mem_addr    = '0;
        w_mem_data_in = '0;
        w_fill_we     = 1'b0;
        w_fill_word   = '0;
        w_fill_data   = '0;
        w_tag_we      = 1'b0;
        w_i_done      = 1'b0;
        w_d_done      = 1'b0;
        w_wr_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_issue_nxt = '0;
                w_recv_nxt  = '0;
                // D side first: it is older in the pipeline, so stalling it behind an I fill could deadlock.
                if (bus.dcache_miss) begin
                    w_state_nxt  = S_FILL;
                    w_target_nxt = 1'b1;
                    w_base_nxt   = {bus.dcache_miss_addr[ADDR_W-1:4], 4'h0};
                end else if (bus.dcache_wr) begin
                    w_state_nxt   = S_WRITE;
                    w_wr_addr_nxt = bus.dcache_wr_addr;
                    w_wr_data_nxt = bus.dcache_wr_data;
                end else if (bus.icache_miss) begin
                    w_state_nxt  = S_FILL;
                    w_target_nxt = 1'b0;
                    w_base_nxt   = {bus.icache_miss_addr[ADDR_W-1:4], 4'h0};
                end
            end
            S_FILL: begin
                if (r_issue_cnt < NWORDS) begin
                    w_mem_enable = 1'b1;
                    w_mem_addr   = r_base + {{(ADDR_W-4){1'b0}}, r_issue_cnt[2:0], 1'b0};
                    w_issue_nxt  = r_issue_cnt + 4'd1;
                end
                if (bus.mem_data_valid) begin
                    w_fill_we   = 1'b1;
                    w_fill_word = r_recv_cnt[2:0];
                    w_fill_data = bus.mem_data_out;
                    w_recv_nxt  = r_recv_cnt + 4'd1;
                    if (r_recv_cnt == LAST_WORD) begin
                        w_tag_we    = 1'b1;
                        w_i_done    = ~r_target;
                        w_d_done    = r_target;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                w_mem_enable  = 1'b1;
                w_mem_wr      = 1'b1;
                w_mem_addr    = r_wr_addr;
                w_mem_data_in = r_wr_data;
                w_wr_done     = 1'b1;
                w_state_nxt   = S_DONE;
            end
            S_DONE: begin
                // Requester drops its request during this cycle, so nothing is sampled here.
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.mem_enable  = w_mem_enable;
    assign bus.mem_wr      = w_mem_wr;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_data_in = w_mem_data_in;
    assign bus.fill_we     = w_fill_we;
    assign bus.fill_target = r_target;
    assign bus.fill_word   = w_fill_word;
    assign bus.fill_data   = w_fill_data;
    assign bus.tag_we      = w_tag_we;
    assign bus.i_fill_done = w_i_done;
    assign bus.d_fill_done = w_d_done;
    assign bus.d_wr_done   = w_wr_done;
    assign bus.busy        = (r_state != S_IDLE);
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: latency-pipe memory, timeline model of arbitration and fill/store timing,
// per-cycle compare against the model plus literal expectations from the directed scenarios.
module tb_cache_mem_arbiter;
  localparam int LAT  = 4;
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus();
  logic [1:0] dbg_state;

  cache_mem_arbiter #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(LAT), .ADDR_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory: fixed-latency read pipe, contents derived from address
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[15:4], 1'b0, a[3:1]} ^ 16'h1040;
  endfunction

  logic        rd_v [LAT];
  logic [15:0] rd_d [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        rd_v[i] <= 1'b0;
        rd_d[i] <= 16'h0;
      end
    end else begin
      rd_v[0] <= bus.mem_enable & ~bus.mem_wr;
      rd_d[0] <= mem_word(bus.mem_addr);
      for (int i = 1; i < LAT; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
    end
  end

  assign bus.mem_data_valid = rd_v[LAT-1] | stray;
  assign bus.mem_data_out   = rd_d[LAT-1];

  // ---------------- scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  // ---------------- timeline model: expected outputs per cycle number
  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        fwe;
    logic [2:0]  word;
    logic [15:0] fdata;
    logic        tgt;
    logic        tag;
    logic        idone;
    logic        ddone;
    logic        wdone;
    logic        busy;
  } exp_t;

  exp_t exp_tab [NCYC];
  int   next_idle = 0;

  task automatic sched_fill(input int t, input logic [15:0] a, input logic tgt);
    logic [15:0] b;
    int last;
    b = {a[15:4], 4'h0};
    last = t + LAT + 8;
    for (int j = 0; j < 8; j++) begin
      exp_tab[t+1+j].en          <= 1'b1;
      exp_tab[t+1+j].addr        <= b + 16'(2*j);
      exp_tab[t+1+LAT+j].fwe     <= 1'b1;
      exp_tab[t+1+LAT+j].word    <= 3'(j);
      exp_tab[t+1+LAT+j].fdata   <= mem_word(b + 16'(2*j));
      exp_tab[t+1+LAT+j].tgt     <= tgt;
    end
    exp_tab[last].tag   <= 1'b1;
    exp_tab[last].idone <= ~tgt;
    exp_tab[last].ddone <= tgt;
    for (int k = t + 1; k <= last + 1; k++) exp_tab[k].busy <= 1'b1;
    next_idle <= last + 2;
  endtask

  task automatic sched_wr(input int t, input logic [15:0] a, input logic [15:0] d);
    exp_tab[t+1].en    <= 1'b1;
    exp_tab[t+1].wr    <= 1'b1;
    exp_tab[t+1].addr  <= a;
    exp_tab[t+1].din   <= d;
    exp_tab[t+1].wdone <= 1'b1;
    exp_tab[t+1].busy  <= 1'b1;
    exp_tab[t+2].busy  <= 1'b1;
    next_idle <= t + 3;
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = cyc; i < NCYC; i++) exp_tab[i] <= '0;
      next_idle <= cyc + 1;
    end else if (cyc >= next_idle && cyc < NCYC - 32) begin
      if (bus.dcache_miss)      sched_fill(cyc, bus.dcache_miss_addr, 1'b1);
      else if (bus.dcache_wr)   sched_wr(cyc, bus.dcache_wr_addr, bus.dcache_wr_data);
      else if (bus.icache_miss) sched_fill(cyc, bus.icache_miss_addr, 1'b0);
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      check("mem_enable", bus.mem_enable, exp_tab[cyc].en);
      check("mem_wr", bus.mem_wr, exp_tab[cyc].wr);
      if (exp_tab[cyc].en) check("mem_addr", bus.mem_addr, exp_tab[cyc].addr);
      if (exp_tab[cyc].wr) check("mem_data_in", bus.mem_data_in, exp_tab[cyc].din);
      check("fill_we", bus.fill_we, exp_tab[cyc].fwe);
      if (exp_tab[cyc].fwe) begin
        check("fill_word", bus.fill_word, exp_tab[cyc].word);
        check("fill_data", bus.fill_data, exp_tab[cyc].fdata);
      end
      if (exp_tab[cyc].fwe || exp_tab[cyc].tag) check("fill_target", bus.fill_target, exp_tab[cyc].tgt);
      check("tag_we", bus.tag_we, exp_tab[cyc].tag);
      check("i_fill_done", bus.i_fill_done, exp_tab[cyc].idone);
      check("d_fill_done", bus.d_fill_done, exp_tab[cyc].ddone);
      check("d_wr_done", bus.d_wr_done, exp_tab[cyc].wdone);
      check("busy", bus.busy, exp_tab[cyc].busy);
    end
  end

  // ---------------- drivers
  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic do_imiss(input logic [15:0] a);
    logic seen;
    seen = 1'b0;
    bus.icache_miss_addr = a;
    bus.icache_miss = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.i_fill_done) seen = 1'b1;
    end
    check("i_fill_done_seen", seen, 1);
    @(posedge clk); #1;
    bus.icache_miss = 1'b0;
  endtask

  task automatic do_dmiss(input logic [15:0] a);
    logic seen;
    seen = 1'b0;
    bus.dcache_miss_addr = a;
    bus.dcache_miss = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.d_fill_done) seen = 1'b1;
    end
    check("d_fill_done_seen", seen, 1);
    @(posedge clk); #1;
    bus.dcache_miss = 1'b0;
  endtask

  task automatic do_dwr(input logic [15:0] a, input logic [15:0] d);
    logic seen;
    seen = 1'b0;
    bus.dcache_wr_addr = a;
    bus.dcache_wr_data = d;
    bus.dcache_wr = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.d_wr_done) seen = 1'b1;
    end
    check("d_wr_done_seen", seen, 1);
    @(posedge clk); #1;
    bus.dcache_wr = 1'b0;
  endtask

  // ---------------- literal expectations for the directed scenarios
  task automatic lit_imiss_0046();
    int t0;
    t0 = cyc;
    at_cycle(t0 + 1);
    check("t1_first_addr", bus.mem_addr, 16'h0040);
    at_cycle(t0 + 5);
    check("t1_first_fill_we", bus.fill_we, 1);
    check("t1_first_word", bus.fill_word, 0);
    check("t1_first_data", bus.fill_data, 16'h1000);
    at_cycle(t0 + 8);
    check("t1_last_addr", bus.mem_addr, 16'h004E);
    at_cycle(t0 + 9);
    check("t1_issue_stops", bus.mem_enable, 0);
    at_cycle(t0 + 12);
    check("t1_last_word", bus.fill_word, 7);
    check("t1_last_data", bus.fill_data, 16'h1007);
    check("t1_tag_we", bus.tag_we, 1);
    check("t1_i_done", bus.i_fill_done, 1);
    check("t1_target", bus.fill_target, 0);
    at_cycle(t0 + 13);
    check("t1_done_state_busy", bus.busy, 1);
    at_cycle(t0 + 14);
    check("t1_idle_busy", bus.busy, 0);
  endtask

  task automatic lit_dual();
    int t0;
    t0 = cyc;
    at_cycle(t0 + 1);
    check("t2_d_first_addr", bus.mem_addr, 16'h2000);
    at_cycle(t0 + 12);
    check("t2_d_done", bus.d_fill_done, 1);
    check("t2_no_i_done", bus.i_fill_done, 0);
    check("t2_d_target", bus.fill_target, 1);
    check("t2_d_last_data", bus.fill_data, 16'h3047);
    at_cycle(t0 + 15);
    check("t2_i_first_en", bus.mem_enable, 1);
    check("t2_i_first_addr", bus.mem_addr, 16'h0100);
    at_cycle(t0 + 26);
    check("t2_i_done", bus.i_fill_done, 1);
    check("t2_i_target", bus.fill_target, 0);
  endtask

  task automatic lit_store();
    int t0;
    t0 = cyc;
    at_cycle(t0 + 1);
    check("t3_en", bus.mem_enable, 1);
    check("t3_wr", bus.mem_wr, 1);
    check("t3_addr", bus.mem_addr, 16'h3002);
    check("t3_data", bus.mem_data_in, 16'hBEEF);
    check("t3_wr_done", bus.d_wr_done, 1);
    at_cycle(t0 + 2);
    check("t3_done_busy", bus.busy, 1);
    at_cycle(t0 + 3);
    check("t3_idle_busy", bus.busy, 0);
  endtask

  task automatic lit_store_during_fill();
    int t0;
    t0 = cyc;
    at_cycle(t0 + 12);
    check("t4_i_done", bus.i_fill_done, 1);
    check("t4_no_wr_yet", bus.d_wr_done, 0);
    at_cycle(t0 + 15);
    check("t4_wr", bus.mem_wr, 1);
    check("t4_addr", bus.mem_addr, 16'h4010);
    check("t4_data", bus.mem_data_in, 16'h1234);
    check("t4_wr_done", bus.d_wr_done, 1);
  endtask

  // ---------------- main sequence
  initial begin
    bus.icache_miss = 1'b0;
    bus.icache_miss_addr = 16'h0;
    bus.dcache_miss = 1'b0;
    bus.dcache_miss_addr = 16'h0;
    bus.dcache_wr = 1'b0;
    bus.dcache_wr_addr = 16'h0;
    bus.dcache_wr_data = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_enable", bus.mem_enable, 0);
    check("rst_fill_we", bus.fill_we, 0);
    check("rst_tag_we", bus.tag_we, 0);
    check("rst_fill_target", bus.fill_target, 0);
    check("rst_state", dbg_state, 0);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // I-miss with unaligned address
    fork
      do_imiss(16'h0046);
      lit_imiss_0046();
    join
    @(posedge clk); #1;

    // mem_data_valid while idle must not write the cache
    stray = 1'b1;
    @(negedge clk);
    check("stray_fill_we", bus.fill_we, 0);
    check("stray_tag_we", bus.tag_we, 0);
    @(posedge clk); #1;
    stray = 1'b0;
    @(posedge clk); #1;

    // I and D miss in the same cycle
    fork
      do_dmiss(16'h2008);
      do_imiss(16'h0100);
      lit_dual();
    join
    @(posedge clk); #1;

    // store on its own
    fork
      do_dwr(16'h3002, 16'hBEEF);
      lit_store();
    join
    @(posedge clk); #1;

    // store arriving mid-fill waits for the fill to finish
    fork
      do_imiss(16'h0A10);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_dwr(16'h4010, 16'h1234);
      end
      lit_store_during_fill();
    join
    @(posedge clk); #1;

    // asynchronous reset in the middle of a fill
    begin
      int t0;
      t0 = cyc;
      bus.icache_miss_addr = 16'h0C00;
      bus.icache_miss = 1'b1;
      at_cycle(t0 + 7);
      #1;
      rst_n = 1'b0;
      bus.icache_miss = 1'b0;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_mem_enable", bus.mem_enable, 0);
      check("arst_fill_we", bus.fill_we, 0);
      check("arst_tag_we", bus.tag_we, 0);
      check("arst_i_done", bus.i_fill_done, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end

    fork
      do_imiss(16'h0C06);
    join
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
